// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared definitions for the RAM-backed FIFO controller.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_DEPTH : default geometry (16x8 RAM macro)
//   ptr_t   : read/write pointer, ADDR_WIDTH+1 bits (MSB is the wrap bit)
//   level_t : words held, 0..DEPTH+1
//   ptr_occ : RAM occupancy from a write/read pointer pair
package ram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0] level_t;

  // Modulo subtraction; the wrap bit makes full and empty distinguishable.
  function automatic ptr_t ptr_occ(input ptr_t wr, input ptr_t rd);
    return wr - rd;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: stream bundle of the FIFO controller.
//   s_valid/s_data/s_ready : upstream write stream
//   m_valid/m_data/m_ready : downstream registered output stream
// Modports: slave = FIFO side, master = producer/consumer side.
interface ram_fifo_ctrl_if
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping FIFO pointer with increment enable.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   i_inc    : advance the pointer by one on the next rising edge
//   o_ptr    : ADDR_WIDTH+1 bit pointer; low bits address the RAM, MSB is the wrap bit
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inc,
  output logic [ADDR_WIDTH:0] o_ptr
);

  logic [ADDR_WIDTH:0] r_ptr;

  // Natural binary roll-over: low bits wrap at 2**ADDR_WIDTH and the MSB toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller around an external 16x8 dual-port RAM
// (port 0 write, port 1 combinational read). Owns the pointers, flags and a
// registered first-word-fall-through output stage.
//   clk, rst        : single clock, asynchronous active-high reset
//   bus (slave)     : s_valid/s_data/s_ready in, m_valid/m_data/m_ready out
//   level           : RAM occupancy plus the word held in the output register
//   full, empty     : RAM occupancy == DEPTH, level == 0
//   ram_wr_en, ram_port_en_0, ram_addr_0, ram_wr_data : RAM port 0 (write)
//   ram_port_en_1, ram_addr_1, ram_rd_data            : RAM port 1 (read)
//   almost_full, almost_empty : only when RAM_FIFO_CTRL_ALMOST_EN is defined
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_fifo_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_wr_en,
  output logic                  ram_port_en_0,
  output logic [ADDR_WIDTH-1:0] ram_addr_0,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_port_en_1,
  output logic [ADDR_WIDTH-1:0] ram_addr_1,
`ifdef RAM_FIFO_CTRL_ALMOST_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
      $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_thresh_chk
      $error("ram_fifo_ctrl: AE_THRESH must be below AF_THRESH");
    end
  endgenerate

  logic [ADDR_WIDTH:0]   w_wr_ptr;
  logic [ADDR_WIDTH:0]   w_rd_ptr;
  logic [ADDR_WIDTH:0]   w_ram_occ;
  logic                  w_full;
  logic                  w_ram_empty;
  logic                  w_push;
  logic                  w_load;
  logic                  w_pop;
  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;

  assign w_ram_occ   = w_wr_ptr - w_rd_ptr;
  assign w_full      = (w_ram_occ == LP_DEPTH);
  assign w_ram_empty = (w_ram_occ == '0);

  // s_ready comes only from registered state: a slot freed by a load this
  // cycle is not offered upstream until the next cycle.
  assign w_push = bus.s_valid & ~w_full;
  // Refill the output register whenever it is empty or being drained.
  assign w_load = ~w_ram_empty & (~r_vld_p1 | bus.m_ready);
  assign w_pop  = r_vld_p1 & bus.m_ready & ~w_load;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_load),
    .o_ptr (w_rd_ptr)
  );

  // ---- stage p1: RAM read port -> registered output word ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (w_load) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= ram_rd_data;
    end else if (w_pop) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign bus.s_ready  = ~w_full;
  assign bus.m_valid  = r_vld_p1;
  assign bus.m_data   = r_data_p1;

  assign level = w_ram_occ + (ADDR_WIDTH+1)'(r_vld_p1);
  assign full  = w_full;
  assign empty = (level == '0);

  assign ram_wr_en     = w_push;
  assign ram_port_en_0 = w_push;
  assign ram_addr_0    = w_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data   = bus.s_data;
  assign ram_port_en_1 = 1'b1;
  assign ram_addr_1    = w_rd_ptr[ADDR_WIDTH-1:0];

`ifdef RAM_FIFO_CTRL_ALMOST_EN
  logic [ADDR_WIDTH:0] w_occ_nxt;
  logic [ADDR_WIDTH:0] w_level_nxt;
  logic                w_vld_nxt;
  logic                r_almost_full;
  logic                r_almost_empty;

  // Flags are registered from the level the FIFO will hold after this edge,
  // so they line up with the registered level rather than lagging it.
  always_comb begin
    w_occ_nxt   = w_ram_occ + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_load);
    w_vld_nxt   = w_load | (r_vld_p1 & ~w_pop);
    w_level_nxt = w_occ_nxt + (ADDR_WIDTH+1)'(w_vld_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_level_nxt >= (ADDR_WIDTH+1)'(AF_THRESH));
      r_almost_empty <= (w_level_nxt <= (ADDR_WIDTH+1)'(AE_THRESH));
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with a behavioural
// 16x8 RAM and a queue-based reference model. Covers the almost flags when
// RAM_FIFO_CTRL_ALMOST_EN is defined.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   level;
  logic          full, empty;
  logic          ram_wr_en, ram_port_en_0, ram_port_en_1;
  logic [AW-1:0] ram_addr_0, ram_addr_1;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
`ifdef RAM_FIFO_CTRL_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .ram_wr_en     (ram_wr_en),
    .ram_port_en_0 (ram_port_en_0),
    .ram_addr_0    (ram_addr_0),
    .ram_wr_data   (ram_wr_data),
    .ram_port_en_1 (ram_port_en_1),
    .ram_addr_1    (ram_addr_1),
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
`endif
    .ram_rd_data   (ram_rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM macro: synchronous write on port 0, combinational read on port 1.
  logic [DW-1:0] mem [DP];
  always @(posedge clk) begin
    if (ram_wr_en && ram_port_en_0) mem[ram_addr_0] <= ram_wr_data;
  end
  assign ram_rd_data = ram_port_en_1 ? mem[ram_addr_1] : 'x;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sv, input logic [DW-1:0] sd, input bit mr);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
  endtask

  // Reference model: a queue holds the words inside the RAM, plus the output word.
  logic [DW-1:0] mq[$];
  bit            m_mv;
  logic [DW-1:0] m_md;
  int            wr_cnt, rd_cnt;
  bit            m_af, m_ae;

  task automatic model_clear();
    mq.delete();
    m_mv = 0; m_md = '0; wr_cnt = 0; rd_cnt = 0; m_af = 0; m_ae = 1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic model_check();
    int occ;
    int lvl;
    occ = mq.size();
    lvl = occ + (m_mv ? 1 : 0);
    chk("m_valid", 32'(bus.m_valid), 32'(m_mv));
    chk("m_data", 32'(bus.m_data), 32'(m_md));
    chk("level", 32'(level), 32'(lvl));
    chk("full", 32'(full), 32'(occ == DP));
    chk("empty", 32'(empty), 32'(lvl == 0));
    chk("s_ready", 32'(bus.s_ready), 32'(occ < DP));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(bus.s_valid && occ < DP));
    chk("ram_port_en_0", 32'(ram_port_en_0), 32'(bus.s_valid && occ < DP));
    chk("ram_port_en_1", 32'(ram_port_en_1), 32'd1);
    chk("ram_addr_0", 32'(ram_addr_0), 32'(wr_cnt % DP));
    chk("ram_addr_1", 32'(ram_addr_1), 32'(rd_cnt % DP));
    chk("ram_wr_data", 32'(ram_wr_data), 32'(bus.s_data));
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
  endtask

  task automatic model_step();
    bit push;
    bit load;
    int lvl;
    push = bus.s_valid && (mq.size() < DP);
    load = (mq.size() > 0) && (!m_mv || bus.m_ready);
    if (load) begin
      m_md = mq.pop_front();
      m_mv = 1;
      rd_cnt++;
    end else if (m_mv && bus.m_ready) begin
      m_mv = 0;
    end
    if (push) begin
      mq.push_back(bus.s_data);
      wr_cnt++;
    end
    lvl  = mq.size() + (m_mv ? 1 : 0);
    m_af = (lvl >= 12);
    m_ae = (lvl <= 2);
  endtask

  typedef struct {
    bit            sv;
    logic [DW-1:0] sd;
    bit            mr;
    bit            e_mv;
    logic [DW-1:0] e_md;
    int            e_lvl;
    bit            e_sr;
    bit            e_we;
    int            e_a0;
  } vec_t;

  vec_t vt[11];

  initial begin
    int sent, got, bubbles, maxlvl;
    bit started;
    int pv, pm;

    // sv, sd, mr | m_valid, m_data, level, s_ready, wr_en, addr0
    vt[0]  = '{1, 8'hA5, 0, 0, 8'h00, 0, 1, 1, 0};
    vt[1]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1};
    vt[2]  = '{0, 8'h00, 0, 1, 8'hA5, 1, 1, 0, 1};
    vt[3]  = '{0, 8'h00, 1, 1, 8'hA5, 1, 1, 0, 1};
    vt[4]  = '{0, 8'h00, 0, 0, 8'hA5, 0, 1, 0, 1};
    vt[5]  = '{1, 8'h11, 1, 0, 8'hA5, 0, 1, 1, 1};
    vt[6]  = '{1, 8'h22, 1, 0, 8'hA5, 1, 1, 1, 2};
    vt[7]  = '{1, 8'h33, 1, 1, 8'h11, 2, 1, 1, 3};
    vt[8]  = '{0, 8'h00, 1, 1, 8'h22, 2, 1, 0, 4};
    vt[9]  = '{0, 8'h00, 1, 1, 8'h33, 1, 1, 0, 4};
    vt[10] = '{0, 8'h00, 0, 0, 8'h33, 0, 1, 0, 4};

    rst = 1'b1;
    drive(0, '0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_addr_0", 32'(ram_addr_0), 32'd0);
    chk("rst_addr_1", 32'(ram_addr_1), 32'd0);
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
    tick();

    // Table-driven vectors: single word latency, then back-to-back flow
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].sv, vt[i].sd, vt[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(vt[i].e_mv));
      chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(vt[i].e_md));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].e_lvl));
      chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(vt[i].e_sr));
      chk($sformatf("vec%0d_wr_en", i), 32'(ram_wr_en), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_addr_0", i), 32'(ram_addr_0), 32'(vt[i].e_a0));
      tick();
    end

    // Fill to full with 17 words, 18th held upstream
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, DW'(k), 0);
      @(negedge clk);
      chk($sformatf("fill%0d_s_ready", k), 32'(bus.s_ready), 32'd1);
      tick();
    end
    drive(1, 8'h11, 0);
    @(negedge clk);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_s_ready", 32'(bus.s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd17);
    chk("full_m_data", 32'(bus.m_data), 32'h00);
    chk("full_wr_en", 32'(ram_wr_en), 32'd0);
    tick();

    // One-cycle m_ready pulse from full: push still blocked that cycle
    drive(1, 8'h11, 1);
    @(negedge clk);
    chk("pulse_s_ready", 32'(bus.s_ready), 32'd0);
    chk("pulse_wr_en", 32'(ram_wr_en), 32'd0);
    tick();
    drive(1, 8'h11, 0);
    @(negedge clk);
    chk("after_m_data", 32'(bus.m_data), 32'h01);
    chk("after_s_ready", 32'(bus.s_ready), 32'd1);
    chk("after_level", 32'(level), 32'd16);
    chk("after_full", 32'(full), 32'd0);
    tick();

    // Reset mid-stream at level 9
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1, DW'(8'h40 + k), 0);
      tick();
    end
    drive(0, '0, 0);
    @(negedge clk);
    chk("pre_rst_level", 32'(level), 32'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("midrst_addr_0", 32'(ram_addr_0), 32'd0);
    chk("midrst_addr_1", 32'(ram_addr_1), 32'd0);
    tick();

    // Continuous streaming of 40 words with m_ready held high
    do_reset();
    sent = 0; got = 0; bubbles = 0; maxlvl = 0; started = 0;
    for (int c = 0; c < 100 && got < 40; c++) begin
      drive(sent < 40, DW'(sent), 1);
      @(negedge clk);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (bus.m_valid) begin
        chk("stream_data", 32'(bus.m_data), 32'(got));
        got++;
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      if (bus.s_valid && bus.s_ready) sent++;
      tick();
    end
    drive(0, '0, 0);
    chk("stream_count", 32'(got), 32'd40);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_level_le2", 32'(maxlvl <= 2), 32'd1);
    @(negedge clk);
    chk("stream_addr_0", 32'(ram_addr_0), 32'd8);
    chk("stream_addr_1", 32'(ram_addr_1), 32'd8);
    chk("stream_empty", 32'(empty), 32'd1);
    tick();

`ifdef RAM_FIFO_CTRL_ALMOST_EN
    // Almost flags while filling 12 words with no reads
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1, DW'(k), 0);
      tick();
      drive(0, '0, 0);
      @(negedge clk);
      chk($sformatf("alm%0d_level", k + 1), 32'(level), 32'(k + 1));
      chk($sformatf("alm%0d_af", k + 1), 32'(almost_full), 32'(k + 1 >= 12));
      chk($sformatf("alm%0d_ae", k + 1), 32'(almost_empty), 32'(k + 1 <= 2));
    end
    tick();
`endif

    // Randomised traffic against the reference model
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      pv = (ph == 0) ? 85 : (ph == 1) ? 30 : 60;
      pm = (ph == 0) ? 25 : (ph == 1) ? 85 : 60;
      for (int c = 0; c < 250; c++) begin
        drive($urandom_range(0, 99) < pv, DW'($urandom), $urandom_range(0, 99) < pm);
        @(negedge clk);
        model_check();
        model_step();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
